// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg
//   Shared constants for the memory-mapped UART transmitter: register word
//   offsets, STATUS/CTRL bit positions and the transmit FSM state encoding.
//   Imported by the top module with "import mmio_uart_tx_pkg::*".
package mmio_uart_tx_pkg;

    // Register word offsets (addr[3:2])
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_DIVISOR = 2'd3;

    // STATUS bit positions
    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_COUNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_IRQEN_BIT = 1;

    // Transmit FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if
//   CPU data-bus responder port of the UART transmitter.
//   sel       : decoder select, peripheral addressed this cycle
//   we        : write strobe, qualified by sel
//   wrMask    : byte-lane enables for writes
//   addr      : byte offset within the peripheral ([1:0] ignored)
//   writeData : lane-shifted store data
//   readData  : combinational register read, 0 when sel is low
//   Modports: master (CPU side), slave (peripheral side).
interface mmio_uart_tx_if;
    logic        sel;
    logic        we;
    logic [3:0]  wrMask;
    logic [3:0]  addr;
    logic [31:0] writeData;
    logic [31:0] readData;

    modport master (output sel, output we, output wrMask, output addr,
                    output writeData, input readData);
    modport slave  (input sel, input we, input wrMask, input addr,
                    input writeData, output readData);
endinterface

// File: rtl/mmio_uart_tx_tx_fifo.sv
// tx_fifo
//   Synchronous FIFO with wrap-around pointers one bit wider than the index,
//   so full and empty are distinguished by the extra MSB.
//   Ports: clk, reset (sync, active-low), push/wdata, pop/rdata (head,
//   combinational), full, empty, count (0..DEPTH).
//   A push while full is ignored even if a pop happens in the same cycle;
//   a pop while empty is ignored.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign count     = wr_ptr_q - rd_ptr_q;
    assign rdata     = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Next pointer values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset flushes the FIFO
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter on the CPU data bus.
//   Ports:
//     clk   : single clock, rising edge
//     reset : synchronous, active-low
//     bus   : mmio_uart_tx_if.slave (sel/we/wrMask/addr/writeData/readData)
//     txd   : serial line, idle high, registered
//     irq   : level interrupt (FIFO drained and idle), registered
//   Registers: 0x0 DATA (W), 0x4 STATUS, 0x8 CTRL, 0xC DIVISOR.
//   Optional feature macro: MMIO_UART_TX_IRQ_EN. When undefined, irq is
//   tied low and CTRL bit1 reads 0 and ignores writes.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          txd,
    output logic          irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic        wr_s;
    logic [1:0]  reg_s;
    logic        push_s;
    logic        ovf_clr_s;
    logic        ctrl_wr_s;
    logic        div_wr_s;
    logic [31:0] rdata_s;
    logic        unused_bus_s;

    // FIFO
    logic          pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [7:0]    fifo_rdata_s;

    // State
    tx_state_e   state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        enable_q, enable_d;
    logic [15:0] divisor_q, divisor_d;
    logic        overflow_q, overflow_d;
    logic        irq_en_s;
    logic        busy_s;

    assign wr_s      = bus.sel && bus.we;
    assign reg_s     = bus.addr[3:2];
    assign push_s    = wr_s && (reg_s == REG_DATA) && bus.wrMask[0];
    assign ovf_clr_s = wr_s && (reg_s == REG_STATUS) && bus.wrMask[0] &&
                       bus.writeData[ST_OVF_BIT];
    assign ctrl_wr_s = wr_s && (reg_s == REG_CTRL) && bus.wrMask[0];
    assign div_wr_s  = wr_s && (reg_s == REG_DIVISOR);
    assign busy_s    = (state_q != S_IDLE);
    assign txd       = txd_q;

    // Bus bits with no register behind them
    assign unused_bus_s = ^{bus.addr[1:0], bus.wrMask[3:2], bus.writeData[31:16]};

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (bus.writeData[7:0]),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Software-visible register updates
    always_comb begin
        enable_d   = enable_q;
        divisor_d  = divisor_q;
        overflow_d = overflow_q;
        if (ctrl_wr_s) begin
            enable_d = bus.writeData[CTRL_EN_BIT];
        end else begin
            enable_d = enable_q;
        end
        if (div_wr_s && bus.wrMask[0]) begin
            divisor_d[7:0] = bus.writeData[7:0];
        end else begin
            divisor_d[7:0] = divisor_q[7:0];
        end
        if (div_wr_s && bus.wrMask[1]) begin
            divisor_d[15:8] = bus.writeData[15:8];
        end else begin
            divisor_d[15:8] = divisor_q[15:8];
        end
        // A dropped push wins over a same-cycle clear can't happen (different
        // offsets), but set still takes priority for clarity.
        if (push_s && fifo_full_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Transmit FSM next-state; bit timer reloads from live DIVISOR at each bit start
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (enable_q && !fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_rdata_s;
                    txd_d   = 1'b0;
                    timer_d = divisor_q;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (timer_q == 16'd0) begin
                    state_d   = S_DATA;
                    txd_d     = shift_q[0];
                    timer_d   = divisor_q;
                    bit_idx_d = 3'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (timer_q == 16'd0) begin
                    timer_d = divisor_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_STOP: begin
                if (timer_q == 16'd0) begin
                    // Chain straight into the next frame so there is no idle gap
                    if (enable_q && !fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_rdata_s;
                        txd_d   = 1'b0;
                        timer_d = divisor_q;
                        state_d = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Main state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            timer_q    <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            txd_q      <= 1'b1;
            enable_q   <= 1'b0;
            divisor_q  <= DEFAULT_DIV;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            enable_q   <= enable_d;
            divisor_q  <= divisor_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef MMIO_UART_TX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    // Interrupt enable and drained-and-idle level interrupt
    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr_s) begin
            irq_en_d = bus.writeData[CTRL_IRQEN_BIT];
        end else begin
            irq_en_d = irq_en_q;
        end
        irq_d = irq_en_q && fifo_empty_s && !busy_s;
    end

    // Interrupt registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en_s = irq_en_q;
    assign irq      = irq_q;
`else
    assign irq_en_s = 1'b0;
    assign irq      = 1'b0;
`endif

    // Zero-latency register read of pre-edge state
    always_comb begin
        rdata_s = 32'd0;
        if (bus.sel) begin
            case (reg_s)
                REG_STATUS: begin
                    rdata_s[ST_FULL_BIT]          = fifo_full_s;
                    rdata_s[ST_EMPTY_BIT]         = fifo_empty_s;
                    rdata_s[ST_BUSY_BIT]          = busy_s;
                    rdata_s[ST_OVF_BIT]           = overflow_q;
                    rdata_s[ST_COUNT_LSB +: 8]    = 8'(fifo_count_s);
                end
                REG_CTRL: begin
                    rdata_s[CTRL_EN_BIT]    = enable_q;
                    rdata_s[CTRL_IRQEN_BIT] = irq_en_s;
                end
                REG_DIVISOR: begin
                    rdata_s[15:0] = divisor_q;
                end
                default: begin
                    rdata_s = 32'd0;
                end
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.readData = rdata_s;

endmodule
